frog_pos_ctrl: RTL and testbench
================================

// Module: frog_pos_ctrl
// PURPOSE
//  Parametrised frog position controller: tracks (col,row) on a COLS x ROWS grid from four direction
//  buttons, with press edge-detection, hold-to-auto-repeat, log/platform drift, respawn and event
//  pulses. Sits between the button debouncers and the LED-matrix renderer/collision logic.
// PARAMETERS
//  COLS        16  grid width; col range 0..COLS-1
//  ROWS        16  grid height; row range 0..ROWS-1 (row ROWS-1 = home row)
//  START_COL    7  col loaded on reset/respawn (must be < COLS)
//  START_ROW    0  row loaded on reset/respawn (must be < ROWS)
//  HOLD_CYC    25  cycles a button is held after its first move before auto-repeat starts (>=1)
//  REP_CYC      8  cycles between auto-repeat moves (>=1)
//  COL_W/ROW_W     derived: $clog2(COLS)/$clog2(ROWS), minimum 1
// PORTS
//  clock      in   1      system clock
//  reset_n    in   1      synchronous, active-low reset
//  l,r,u,d    in   1      level buttons (debounced); l: col+1, r: col-1, u: row+1, d: row-1
//  drift_l    in   1      1-cycle pulse: platform carries frog col+1
//  drift_r    in   1      1-cycle pulse: platform carries frog col-1
//  respawn    in   1      1-cycle pulse: return to START_COL/START_ROW
//  freeze     in   1      level: ignore buttons and drift (position held)
//  col        out  COL_W  current column (registered)
//  row        out  ROW_W  current row (registered)
//  moved      out  1      1-cycle pulse: col or row changed due to a button move
//  home       out  1      1-cycle pulse: row became ROWS-1 this cycle
//  edge_kill  out  1      1-cycle pulse: drift tried to push col past 0 or COLS-1
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): col=START_COL, row=START_ROW, moved=home=edge_kill=0, both FSMs IDLE,
//    repeat counters 0. Reset overrides every other input.
//  - Two independent axis FSMs (col: l/r, row: u/d), states IDLE, DELAY, REPEAT.
//    IDLE: exactly one of the pair high -> step once, go DELAY, counter cleared. Both or neither -> stay.
//    DELAY: same button still high, counter reaches HOLD_CYC-1 -> step, go REPEAT, clear counter.
//    REPEAT: counter reaches REP_CYC-1 -> step, clear counter.
//    DELAY/REPEAT: held button released, or opposite button also high -> IDLE, no step.
//  - Latency: step is visible on col/row at the posedge that first samples the button high in IDLE.
//  - Clamping: a step beyond 0 or max is suppressed (no change, moved=0); FSM still advances.
//  - Axes are independent: l+u together moves diagonally in one cycle.
//  - Drift: applies to col only when col FSM makes no step that cycle (button move wins). drift_l and
//    drift_r together cancel. Drift at boundary: col unchanged, edge_kill=1 for one cycle.
//    Drift never asserts moved.
//  - Priority per cycle: reset_n > respawn > freeze > button step > drift.
//  - respawn: col/row load START values next edge, FSMs to IDLE, pulses 0; a button still held afterwards
//    does not move until released and re-pressed (FSMs re-enter IDLE only from released state:
//    a held button after respawn is treated as already consumed).
//  - freeze: position and FSMs held; counters hold; pulses 0. On release, held buttons resume their state.
//  - home: asserted on the edge row transitions to ROWS-1 (not while resting there).
//  - All outputs registered; no combinational input->output path.
// TESTING
//  1 Reset: reset_n=0 two cycles -> col=7,row=0, all pulses 0; release, no buttons -> unchanged 20 cycles.
//  2 Tap: l high 1 cycle -> col=8 next edge, moved=1 one cycle; l held 40 cycles (HOLD 25,REP 8)
//    -> moves at cycle 0,25,33 -> col ends 3 steps higher.
//  3 Clamp: u held from row=14 long enough -> row 15, home=1 once, then no change, moved=0.
//  4 Simultaneous: l+r -> col unchanged; l+u -> col+1,row+1 same edge; l step + drift_r same cycle
//    -> only l applied.
//  5 Drift edge: col=0, drift_r pulse -> col=0, edge_kill=1 one cycle; col=15, drift_l -> edge_kill=1.
//  6 Mid-operation: l held in REPEAT, respawn -> col=7,row=0, no further move until l released and
//    re-pressed; reset_n low during REPEAT -> reset values next edge.

Source files
------------

// File: rtl/frog_pos_ctrl.sv
// Frog position controller: tracks (col,row) on a COLS x ROWS grid from four
// buttons with tap/hold-repeat, platform drift, respawn, freeze and event pulses.

module frog_axis_fsm #(
  parameter int HOLD_CYC = 25,
  parameter int REP_CYC  = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_respawn,
  input  logic i_freeze,
  output logic o_step_inc,
  output logic o_step_dec
);
  localparam int CNT_MAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} axis_st_t;

  axis_st_t         r_st;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;   // 0: inc button owns the hold, 1: dec button
  logic             r_lock;  // set by respawn; a still-held button must be released first

  logic w_one, w_keep, w_inc, w_dec;

  assign w_one  = i_inc ^ i_dec;
  assign w_keep = w_one && (r_dir ? i_dec : i_inc);

  always_comb begin
    w_inc = 1'b0;
    w_dec = 1'b0;
    if (!i_respawn && !i_freeze) begin
      case (r_st)
        IDLE: if (w_one && !r_lock) begin
          w_inc = i_inc;
          w_dec = i_dec;
        end
        DELAY: if (w_keep && r_cnt == HOLD_LAST) begin
          w_inc = !r_dir;
          w_dec = r_dir;
        end
        REPEAT: if (w_keep && r_cnt == REP_LAST) begin
          w_inc = !r_dir;
          w_dec = r_dir;
        end
        default: ;
      endcase
    end
  end

  assign o_step_inc = w_inc;
  assign o_step_dec = w_dec;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_st   <= IDLE;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
      r_lock <= 1'b0;
    end else if (i_respawn) begin
      r_st   <= IDLE;
      r_cnt  <= '0;
      r_lock <= 1'b1;
    end else if (!i_freeze) begin
      r_lock <= r_lock && (i_inc || i_dec);
      case (r_st)
        IDLE: if (w_one && !r_lock) begin
          r_st  <= DELAY;
          r_cnt <= '0;
          r_dir <= i_dec;
        end
        DELAY: begin
          if (!w_keep) begin
            r_st  <= IDLE;
            r_cnt <= '0;
          end else if (r_cnt == HOLD_LAST) begin
            r_st  <= REPEAT;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (!w_keep) begin
            r_st  <= IDLE;
            r_cnt <= '0;
          end else if (r_cnt == REP_LAST) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_st  <= IDLE;
          r_cnt <= '0;
        end
      endcase
    end
  end
endmodule

module frog_pos_ctrl #(
  parameter int COLS      = 16,
  parameter int ROWS      = 16,
  parameter int START_COL = 7,
  parameter int START_ROW = 0,
  parameter int HOLD_CYC  = 25,
  parameter int REP_CYC   = 8,
  parameter int COL_W     = (COLS > 1) ? $clog2(COLS) : 1,
  parameter int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             l,
  input  logic             r,
  input  logic             u,
  input  logic             d,
  input  logic             drift_l,
  input  logic             drift_r,
  input  logic             respawn,
  input  logic             freeze,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             moved,
  output logic             home,
  output logic             edge_kill
);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_RST = COL_W'(START_COL);
  localparam logic [ROW_W-1:0] ROW_RST = ROW_W'(START_ROW);

  logic [COL_W-1:0] r_col, w_col_nxt;
  logic [ROW_W-1:0] r_row, w_row_nxt;
  logic             r_moved, r_home, r_kill;
  logic             w_c_inc, w_c_dec, w_r_inc, w_r_dec;
  logic             w_c_mv, w_r_mv, w_kill;

  frog_axis_fsm #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_col_fsm (
    .clock(clock), .reset_n(reset_n), .i_inc(l), .i_dec(r),
    .i_respawn(respawn), .i_freeze(freeze),
    .o_step_inc(w_c_inc), .o_step_dec(w_c_dec)
  );

  frog_axis_fsm #(.HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_row_fsm (
    .clock(clock), .reset_n(reset_n), .i_inc(u), .i_dec(d),
    .i_respawn(respawn), .i_freeze(freeze),
    .o_step_inc(w_r_inc), .o_step_dec(w_r_dec)
  );

  // Drift only when the column FSM issued no step request; a clamped button step still wins.
  always_comb begin
    w_col_nxt = r_col;
    w_c_mv    = 1'b0;
    w_kill    = 1'b0;
    if (w_c_inc) begin
      if (r_col != COL_MAX) begin
        w_col_nxt = r_col + COL_W'(1);
        w_c_mv    = 1'b1;
      end
    end else if (w_c_dec) begin
      if (r_col != '0) begin
        w_col_nxt = r_col - COL_W'(1);
        w_c_mv    = 1'b1;
      end
    end else if (!respawn && !freeze && (drift_l != drift_r)) begin
      if (drift_l) begin
        if (r_col == COL_MAX) w_kill = 1'b1;
        else                  w_col_nxt = r_col + COL_W'(1);
      end else begin
        if (r_col == '0) w_kill = 1'b1;
        else             w_col_nxt = r_col - COL_W'(1);
      end
    end
  end

  always_comb begin
    w_row_nxt = r_row;
    w_r_mv    = 1'b0;
    if (w_r_inc && r_row != ROW_MAX) begin
      w_row_nxt = r_row + ROW_W'(1);
      w_r_mv    = 1'b1;
    end else if (w_r_dec && r_row != '0) begin
      w_row_nxt = r_row - ROW_W'(1);
      w_r_mv    = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n || respawn) begin
      r_col   <= COL_RST;
      r_row   <= ROW_RST;
      r_moved <= 1'b0;
      r_home  <= 1'b0;
      r_kill  <= 1'b0;
    end else if (freeze) begin
      r_moved <= 1'b0;
      r_home  <= 1'b0;
      r_kill  <= 1'b0;
    end else begin
      r_col   <= w_col_nxt;
      r_row   <= w_row_nxt;
      r_moved <= w_c_mv || w_r_mv;
      r_home  <= (w_row_nxt == ROW_MAX) && (r_row != ROW_MAX);
      r_kill  <= w_kill;
    end
  end

  assign col       = r_col;
  assign row       = r_row;
  assign moved     = r_moved;
  assign home      = r_home;
  assign edge_kill = r_kill;
endmodule

// File: tb/tb_frog_pos_ctrl.sv
// Scoreboarded directed bench for frog_pos_ctrl: each driven cycle queues the
// expected post-edge outputs, a negedge monitor pops and compares.

module tb_frog_pos_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic l = 0, r = 0, u = 0, d = 0;
  logic drift_l = 0, drift_r = 0, respawn = 0, freeze = 0;
  logic [3:0] col, row;
  logic moved, home, edge_kill;

  typedef struct {
    string      nm;
    logic [3:0] col;
    logic [3:0] row;
    logic       mv;
    logic       hm;
    logic       ek;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   ec = 7;
  int   er = 0;

  frog_pos_ctrl dut (
    .clock(clock), .reset_n(reset_n), .l(l), .r(r), .u(u), .d(d),
    .drift_l(drift_l), .drift_r(drift_r), .respawn(respawn), .freeze(freeze),
    .col(col), .row(row), .moved(moved), .home(home), .edge_kill(edge_kill)
  );

  always #5 clock = ~clock;

  // b = {l,r,u,d}, x = {drift_l,drift_r,respawn,freeze}
  task automatic cyc(input string nm, input logic [3:0] b, input logic [3:0] x,
                     input logic rn, input int c, input int rw,
                     input logic mv, input logic hm, input logic ek);
    exp_t e;
    @(negedge clock);
    #1;
    {l, r, u, d} = b;
    {drift_l, drift_r, respawn, freeze} = x;
    reset_n = rn;
    e.nm = nm; e.col = 4'(c); e.row = 4'(rw); e.mv = mv; e.hm = hm; e.ek = ek;
    q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tot++;
      if (col !== e.col || row !== e.row || moved !== e.mv || home !== e.hm || edge_kill !== e.ek)
        $display("FAIL %s: got col=%0d row=%0d moved=%b home=%b edge_kill=%b, expected col=%0d row=%0d moved=%b home=%b edge_kill=%b",
                 e.nm, col, row, moved, home, edge_kill, e.col, e.row, e.mv, e.hm, e.ek);
      else
        n_pass++;
    end
  end

  initial begin
    // 1: reset and idle
    cyc("rst0", 4'b0000, 4'b0000, 1'b0, 7, 0, 0, 0, 0);
    cyc("rst1", 4'b0000, 4'b0000, 1'b0, 7, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc("idle", 4'b0000, 4'b0000, 1'b1, 7, 0, 0, 0, 0);

    // 2: tap, then hold 40 cycles -> steps at 0, 25, 33
    cyc("tap_l", 4'b1000, 4'b0000, 1'b1, 8, 0, 1, 0, 0);
    cyc("tap_rel", 4'b0000, 4'b0000, 1'b1, 8, 0, 0, 0, 0);
    ec = 8;
    for (int i = 0; i < 40; i++) begin
      logic st;
      st = (i == 0 || i == 25 || i == 33);
      if (st) ec++;
      cyc("hold_l", 4'b1000, 4'b0000, 1'b1, ec, 0, st, 0, 0);
    end
    cyc("hold_rel", 4'b0000, 4'b0000, 1'b1, 11, 0, 0, 0, 0);

    // 3: climb to row 14 by taps, then hold u into the clamp
    for (int i = 1; i <= 14; i++) begin
      cyc("tap_u", 4'b0010, 4'b0000, 1'b1, 11, i, 1, 0, 0);
      cyc("tap_u_rel", 4'b0000, 4'b0000, 1'b1, 11, i, 0, 0, 0);
    end
    cyc("u_home", 4'b0010, 4'b0000, 1'b1, 11, 15, 1, 1, 0);
    for (int i = 1; i < 40; i++) cyc("u_clamp", 4'b0010, 4'b0000, 1'b1, 11, 15, 0, 0, 0);
    cyc("u_rel", 4'b0000, 4'b0000, 1'b1, 11, 15, 0, 0, 0);

    // 4: simultaneous buttons and button-vs-drift priority
    cyc("l_and_r", 4'b1100, 4'b0000, 1'b1, 11, 15, 0, 0, 0);
    cyc("lr_rel", 4'b0000, 4'b0000, 1'b1, 11, 15, 0, 0, 0);
    cyc("tap_d", 4'b0001, 4'b0000, 1'b1, 11, 14, 1, 0, 0);
    cyc("d_rel", 4'b0000, 4'b0000, 1'b1, 11, 14, 0, 0, 0);
    cyc("diag_lu", 4'b1010, 4'b0000, 1'b1, 12, 15, 1, 1, 0);
    cyc("diag_rel", 4'b0000, 4'b0000, 1'b1, 12, 15, 0, 0, 0);
    cyc("l_vs_drift", 4'b1000, 4'b0100, 1'b1, 13, 15, 1, 0, 0);
    cyc("lvd_rel", 4'b0000, 4'b0000, 1'b1, 13, 15, 0, 0, 0);
    cyc("drift_l", 4'b0000, 4'b1000, 1'b1, 14, 15, 0, 0, 0);
    cyc("drift_both", 4'b0000, 4'b1100, 1'b1, 14, 15, 0, 0, 0);

    // 5: drift into both edges
    cyc("drift_l15", 4'b0000, 4'b1000, 1'b1, 15, 15, 0, 0, 0);
    cyc("kill_hi", 4'b0000, 4'b1000, 1'b1, 15, 15, 0, 0, 1);
    cyc("kill_hi_end", 4'b0000, 4'b0000, 1'b1, 15, 15, 0, 0, 0);
    for (int i = 14; i >= 0; i--) cyc("drift_r", 4'b0000, 4'b0100, 1'b1, i, 15, 0, 0, 0);
    cyc("kill_lo", 4'b0000, 4'b0100, 1'b1, 0, 15, 0, 0, 1);
    cyc("kill_lo_end", 4'b0000, 4'b0000, 1'b1, 0, 15, 0, 0, 0);
    cyc("r_clamp", 4'b0100, 4'b0000, 1'b1, 0, 15, 0, 0, 0);
    cyc("r_rel", 4'b0000, 4'b0000, 1'b1, 0, 15, 0, 0, 0);

    // 6: respawn while l is in REPEAT; held l stays consumed until re-pressed
    ec = 0;
    for (int i = 0; i < 36; i++) begin
      logic st;
      st = (i == 0 || i == 25 || i == 33);
      if (st) ec++;
      cyc("rep_l", 4'b1000, 4'b0000, 1'b1, ec, 15, st, 0, 0);
    end
    cyc("respawn", 4'b1000, 4'b0010, 1'b1, 7, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) cyc("post_rsp_held", 4'b1000, 4'b0000, 1'b1, 7, 0, 0, 0, 0);
    cyc("post_rsp_rel", 4'b0000, 4'b0000, 1'b1, 7, 0, 0, 0, 0);
    cyc("repress_l", 4'b1000, 4'b0000, 1'b1, 8, 0, 1, 0, 0);
    cyc("repress_rel", 4'b0000, 4'b0000, 1'b1, 8, 0, 0, 0, 0);

    // freeze holds position against buttons and drift
    cyc("frz_l", 4'b1000, 4'b0001, 1'b1, 8, 0, 0, 0, 0);
    cyc("unfrz_l", 4'b1000, 4'b0000, 1'b1, 9, 0, 1, 0, 0);
    cyc("unfrz_rel", 4'b0000, 4'b0000, 1'b1, 9, 0, 0, 0, 0);
    cyc("frz_drift", 4'b0000, 4'b1001, 1'b1, 9, 0, 0, 0, 0);
    cyc("drift_after", 4'b0000, 4'b1000, 1'b1, 10, 0, 0, 0, 0);

    // reset in the middle of REPEAT
    ec = 10;
    for (int i = 0; i < 36; i++) begin
      logic st;
      st = (i == 0 || i == 25 || i == 33);
      if (st) ec++;
      cyc("rep_l2", 4'b1000, 4'b0000, 1'b1, ec, 0, st, 0, 0);
    end
    cyc("rst_mid", 4'b1000, 4'b0000, 1'b0, 7, 0, 0, 0, 0);
    cyc("rst_rel", 4'b0000, 4'b0000, 1'b1, 7, 0, 0, 0, 0);

    repeat (3) @(negedge clock);
    #2;
    n_tot++;
    if (q.size() != 0)
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    else
      n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
